// File: rtl/data_memory_pkg.sv
// Shared definitions for the byte-addressable data memory: size encodings,
// default base address and lane-decode helpers.
package data_memory_pkg;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [1:0]  SZ_RSVD = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Size/alignment violations; the reserved size is always rejected.
  function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_byte_if.sv
// Request/response bundle between a load/store unit and data_memory_byte.
interface data_memory_byte_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  Read_Enable;
  logic                  Write_Enable;
  logic [1:0]            Size;
  logic                  Unsigned;
  logic [DATA_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Write_Data;
  logic [DATA_WIDTH-1:0] Read_Data;
  logic                  Read_Valid;
  logic                  Fault;

  modport master (
    output Read_Enable, Write_Enable, Size, Unsigned, Address, Write_Data,
    input  Read_Data, Read_Valid, Fault
  );

  modport slave (
    input  Read_Enable, Write_Enable, Size, Unsigned, Address, Write_Data,
    output Read_Data, Read_Valid, Fault
  );

endinterface

// File: rtl/load_extend.sv
// Combinational load path: picks the addressed byte/half/word out of a
// stored word and zero- or sign-extends it to 32 bits.
module load_extend
  import data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
    logic signed [7:0] sb;
    sb = b;
    return uns ? {24'h0, b} : 32'(sb);
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
    logic signed [15:0] sh;
    sh = h;
    return uns ? {16'h0, h} : 32'(sh);
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_BYTE: data_o = ext_byte(byte_sel, unsigned_i);
      SZ_HALF: data_o = ext_half(half_sel, unsigned_i);
      SZ_WORD: data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_byte.sv
// Byte-lane data memory with one-cycle registered loads, read-first
// ordering on same-cycle load/store, and a one-cycle Fault pulse.
module data_memory_byte
  import data_memory_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 64,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_byte_if.slave bus
);

  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  logic [3:0][7:0]       mem_q [MEMORY_DEPTH];

  logic [DATA_WIDTH-1:0] rel_addr;
  logic [DATA_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            offset;
  logic                  out_of_range;
  logic                  illegal;
  logic                  request;
  logic [3:0]            lane_en;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] load_ext;

  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  fault_q, fault_d;

  always_comb begin
    rel_addr     = bus.Address - BASE_ADDRESS;
    word_idx     = rel_addr >> 2;
    idx          = word_idx[IDX_W-1:0];
    offset       = bus.Address[1:0];
    out_of_range = (bus.Address < BASE_ADDRESS) ||
                   (word_idx >= DATA_WIDTH'(MEMORY_DEPTH));
    illegal      = out_of_range || bad_size_align(bus.Size, offset);
    request      = bus.Read_Enable || bus.Write_Enable;
    lane_en      = lane_mask(bus.Size, offset);

    // Replicate the right-justified store data so every lane sees its byte.
    case (bus.Size)
      SZ_BYTE: lane_data = {4{bus.Write_Data[7:0]}};
      SZ_HALF: lane_data = {2{bus.Write_Data[15:0]}};
      default: lane_data = bus.Write_Data;
    endcase
  end

  load_extend u_load_extend (
    .word_i     (mem_q[idx]),
    .offset_i   (offset),
    .size_i     (bus.Size),
    .unsigned_i (bus.Unsigned),
    .data_o     (load_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset && bus.Write_Enable && !illegal) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en[l]) mem_q[idx][l] <= lane_data[8*l +: 8];
      end
    end
  end

  always_comb begin
    read_valid_d = bus.Read_Enable;
    fault_d      = request && illegal;
    read_data_d  = read_data_q;
    if (bus.Read_Enable) read_data_d = illegal ? '0 : load_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.Read_Data  = read_data_q;
  assign bus.Read_Valid = read_valid_q;
  assign bus.Fault      = fault_q;

endmodule

// File: tb/tb_data_memory_byte.sv
// Directed plus randomized bench for data_memory_byte against a byte-array
// reference model.
module tb_data_memory_byte;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  mem_m [DEPTH*4];
  logic [31:0] exp_d;
  logic        exp_v;
  logic        exp_f;

  always #5 clk = ~clk;

  data_memory_byte_if #(.DATA_WIDTH(32)) bus ();

  data_memory_byte #(
    .MEMORY_DEPTH (DEPTH),
    .DATA_WIDTH   (32),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_m(input logic [1:0] sz, input logic [31:0] a);
    longint off;
    if (a < BASE) return 0;
    off = longint'(a) - longint'(BASE);
    if (off / 4 >= DEPTH) return 0;
    if (sz == 2'b11) return 0;
    if ((a % (32'd1 << sz)) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] load_m(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int     n;
    int     b;
    longint v;
    n = 1 << sz;
    b = int'(a - BASE);
    v = 0;
    for (int k = 0; k < n; k++) v = v | (longint'(mem_m[b+k]) << (8*k));
    if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic store_m(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    int b;
    n = 1 << sz;
    b = int'(a - BASE);
    for (int k = 0; k < n; k++) mem_m[b+k] = wd[8*k +: 8];
  endtask

  task automatic step(input string tag, input logic rst, input logic re, input logic we,
                      input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd);
    bit lg;
    reset            = rst;
    bus.Read_Enable  = re;
    bus.Write_Enable = we;
    bus.Size         = sz;
    bus.Unsigned     = uns;
    bus.Address      = addr;
    bus.Write_Data   = wd;
    lg = legal_m(sz, addr);
    if (rst) begin
      exp_v = 1'b0;
      exp_f = 1'b0;
      exp_d = '0;
    end else begin
      exp_v = re;
      exp_f = (re || we) && !lg;
      if (re) exp_d = lg ? load_m(sz, uns, addr) : 32'h0;
      if (we && lg) store_m(sz, addr, wd);
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, {31'h0, bus.Read_Valid}, {31'h0, exp_v});
    check({tag, "_fault"}, {31'h0, bus.Fault}, {31'h0, exp_f});
    check({tag, "_data"}, bus.Read_Data, exp_d);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    exp_d = '0;
    exp_v = 1'b0;
    exp_f = 1'b0;

    step("reset0", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
    step("reset1", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0);

    for (int w = 0; w < DEPTH; w++)
      step("init", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, BASE + 32'(4*w), $urandom);

    // Word store then word load.
    step("st_word", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
    step("ld_word", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
    check("ld_word_const", bus.Read_Data, 32'hDEAD_BEEF);

    // Byte store into a zero word, signed/unsigned/word loads.
    step("clr_word", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
    step("st_byte", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h1001_0006, 32'h0000_0080);
    step("ld_sbyte", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0006, 32'h0);
    check("ld_sbyte_const", bus.Read_Data, 32'hFFFF_FF80);
    step("ld_ubyte", 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h1001_0006, 32'h0);
    check("ld_ubyte_const", bus.Read_Data, 32'h0000_0080);
    step("ld_word2", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
    check("ld_word2_const", bus.Read_Data, 32'h0080_0000);

    // Misaligned half load and out-of-range store.
    step("ld_misal", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h1001_0001, 32'h0);
    check("ld_misal_fault", {31'h0, bus.Fault}, 32'h1);
    check("ld_misal_zero", bus.Read_Data, 32'h0);
    idle("after_misal");
    step("st_oor", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_0100, 32'h1234_5678);
    check("st_oor_fault", {31'h0, bus.Fault}, 32'h1);
    step("ld_last", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_00FC, 32'h0);
    step("ld_below", 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h1000_FFFC, 32'h0);
    step("ld_rsvd", 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, BASE, 32'h0);
    idle("hold");

    // Read-first on same-cycle load and store.
    step("st_1111", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, BASE, 32'h1111_1111);
    step("rw_same", 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, BASE, 32'h2222_2222);
    check("rw_same_const", bus.Read_Data, 32'h1111_1111);
    step("ld_after_rw", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
    check("ld_after_rw_const", bus.Read_Data, 32'h2222_2222);

    // Requests during reset are dropped.
    step("rst_store", 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, BASE, 32'hCAFE_F00D);
    check("rst_store_data", bus.Read_Data, 32'h0);
    step("ld_after_rst", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
    check("ld_after_rst_const", bus.Read_Data, 32'h2222_2222);

    // Back-to-back word loads.
    for (int i = 0; i < 4; i++)
      step("b2b", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'(4*i), 32'h0);

    // Randomized traffic around both ends of the window.
    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = BASE - 32'd16 + 32'($urandom_range(0, DEPTH*4 + 32));
      if ($urandom_range(0, 3) != 0) a = BASE + 32'($urandom_range(0, DEPTH*4 - 1));
      step("rand", 1'($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
           sz, 1'($urandom), a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
